// File: rtl/rv32_data_bus.sv
// rv32_data_bus: RV32 core data-side bus with aliased word RAM, a 64-bit
// free-running cycle counter and a byte-wide TX FIFO with sticky overflow.
module rv32_data_bus #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] address_i,
    input  logic [3:0]  write_enable_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   ram [RAM_WORDS];
    logic [63:0]   cycle_cnt;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic          sel_ram;
    logic          sel_periph;
    logic [AW-1:0] ram_idx;
    logic [1:0]    reg_sel;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          ovf_event;
    logic          clear_req;
    logic [31:0]   status_word;
    logic          unused_addr;

    // Address bits above the RAM index alias; the byte offset is unused.
    assign unused_addr = ^{address_i[27:AW+2], address_i[1:0]};

    assign sel_ram    = (address_i[31:28] == 4'h0);
    assign sel_periph = (address_i[31:28] == 4'h1);
    assign ram_idx    = address_i[AW+1:2];
    assign reg_sel    = address_i[3:2];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_req  = sel_periph && (reg_sel == 2'd2) && write_enable_i[0];
    assign pop       = !fifo_empty && tx_ready_i;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign ovf_event = push_req && fifo_full && !pop;
    assign clear_req = sel_periph && (reg_sel == 2'd3) && write_enable_i[2]
                       && write_data_i[16];

    assign status_word = {15'd0, overflow, 6'd0, fifo_full, fifo_empty, 8'(count)};

    assign tx_valid_o = !fifo_empty;
    assign tx_data_o  = fifo_mem[rd_ptr];

    // Combinational read path; a same-cycle write is not visible until the edge.
    always_comb begin
        read_data_o = '0;
        if (sel_ram) begin
            read_data_o = ram[ram_idx];
        end else if (sel_periph) begin
            case (reg_sel)
                2'd0:    read_data_o = cycle_cnt[31:0];
                2'd1:    read_data_o = cycle_cnt[63:32];
                2'd2:    read_data_o = '0;
                default: read_data_o = status_word;
            endcase
        end
    end

    // Byte-lane RAM write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (sel_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (write_enable_i[b]) begin
                    ram[ram_idx][8*b +: 8] <= write_data_i[8*b +: 8];
                end
            end
        end
    end

    // Free-running 64-bit cycle counter, wraps naturally.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
        end
    end

    // TX FIFO pointers, storage, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= write_data_i[7:0];
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (!push_ok && pop) begin
                count <= count - CW'(1);
            end
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (clear_req) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv32_data_bus.sv
// tb_rv32_data_bus: directed scenarios plus randomized traffic, checked every
// cycle against a queue/array model of the bus.
module tb_rv32_data_bus;

    localparam int RW = 1024;
    localparam int FD = 8;

    localparam logic [31:0] A_LO  = 32'h1000_0000;
    localparam logic [31:0] A_HI  = 32'h1000_0004;
    localparam logic [31:0] A_TX  = 32'h1000_0008;
    localparam logic [31:0] A_ST  = 32'h1000_000C;
    localparam logic [31:0] A_IDL = 32'h2000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;

    int n_chk;
    int n_fail;

    // Behavioural model state
    logic [7:0]  mq[$];
    logic [31:0] mram[int];
    logic [3:0]  mval[int];
    logic [63:0] m_cyc;
    logic        m_ovf;

    rv32_data_bus #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .address_i      (address),
        .write_enable_i (wen),
        .write_data_i   (wdata),
        .read_data_o    (read_data),
        .tx_valid_o     (tx_valid),
        .tx_ready_i     (tx_ready),
        .tx_data_o      (tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(mq.size());
        if (mq.size() == 0)  s = s | 32'h0000_0100;
        if (mq.size() == FD) s = s | 32'h0000_0200;
        if (m_ovf)           s = s | 32'h0001_0000;
        return s;
    endfunction

    // Expected read value and the mask of bits the model actually knows.
    function automatic void exp_rd(input logic [31:0] a, output logic [31:0] v, output logic [31:0] m);
        int idx;
        v = '0;
        m = 32'hFFFF_FFFF;
        if (a[31:28] == 4'h0) begin
            idx = int'((a >> 2) % RW);
            m = '0;
            if (mram.exists(idx)) begin
                v = mram[idx];
                for (int b = 0; b < 4; b++)
                    if (mval[idx][b]) m[8*b +: 8] = 8'hFF;
            end
        end else if (a[31:28] == 4'h1) begin
            case (a[3:2])
                2'd0:    v = m_cyc[31:0];
                2'd1:    v = m_cyc[63:32];
                2'd2:    v = '0;
                default: v = m_status();
            endcase
        end
    endfunction

    // Model advance on each edge using the inputs presented during that cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cyc = '0;
            m_ovf = 1'b0;
        end else begin
            bit   do_pop, was_full, pushreq, clr;
            int   idx;
            logic [7:0] tmp;
            was_full = (mq.size() == FD);
            do_pop   = (mq.size() != 0) && tx_ready;
            pushreq  = (address[31:28] == 4'h1) && (address[3:2] == 2'd2) && wen[0];
            clr      = (address[31:28] == 4'h1) && (address[3:2] == 2'd3) && wen[2] && wdata[16];
            if (address[31:28] == 4'h0) begin
                idx = int'((address >> 2) % RW);
                for (int b = 0; b < 4; b++) begin
                    if (wen[b]) begin
                        if (!mram.exists(idx)) begin
                            mram[idx] = '0;
                            mval[idx] = '0;
                        end
                        mram[idx][8*b +: 8] = wdata[8*b +: 8];
                        mval[idx][b] = 1'b1;
                    end
                end
            end
            if (do_pop) tmp = mq.pop_front();
            if (pushreq && (!was_full || do_pop)) mq.push_back(wdata[7:0]);
            if (pushreq && was_full && !do_pop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            m_cyc = m_cyc + 64'd1;
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin : cmp
        logic [31:0] ev, em;
        exp_rd(address, ev, em);
        if (em != 0) chk("read_data", {32'd0, read_data & em}, {32'd0, ev & em});
        chk("tx_valid", {63'd0, tx_valid}, {63'd0, mq.size() != 0});
        if (mq.size() != 0) chk("tx_data", {56'd0, tx_data}, {56'd0, mq[0]});
        else if (!rst_n) chk("tx_data_rst", {56'd0, tx_data}, 64'd0);
    end

    // One bus cycle: inputs change just after the edge, return mid-cycle.
    task automatic cyc(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd, input logic rdy);
        @(posedge clk);
        #1;
        address  = a;
        wen      = we;
        wdata    = wd;
        tx_ready = rdy;
        @(negedge clk);
    endtask

    logic [31:0] v0, v1;
    logic [7:0]  exp_q[$];

    initial begin
        n_chk = 0; n_fail = 0;
        m_cyc = '0; m_ovf = 1'b0;
        rst_n = 1'b0;
        address = A_IDL; wen = '0; wdata = '0; tx_ready = 1'b0;

        // Reset state
        cyc(A_ST, 4'h0, 0, 0);
        chk("rst_status", {32'd0, read_data}, 64'h100);
        chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("rst_tx_data", {56'd0, tx_data}, 64'd0);
        cyc(A_LO, 4'h0, 0, 0);
        chk("rst_cycle_lo", {32'd0, read_data}, 64'd0);
        #2 rst_n = 1'b1;

        // RAM byte lanes, aliasing and read-before-write
        cyc(32'h0000_0100, 4'hF, 32'h1122_3344, 0);
        cyc(32'h0000_0100, 4'h2, 32'h0000_AA00, 0);
        cyc(32'h0000_0100, 4'h0, 0, 0);
        chk("ram_lane", {32'd0, read_data}, 64'h1122_AA44);
        cyc(32'h0000_1100, 4'h0, 0, 0);
        chk("ram_alias", {32'd0, read_data}, 64'h1122_AA44);
        cyc(32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 0);
        chk("ram_rbw", {32'd0, read_data}, 64'h1122_AA44);
        cyc(32'h0000_0100, 4'h0, 0, 0);
        chk("ram_after_w", {32'd0, read_data}, 64'hDEAD_BEEF);
        cyc(32'h3000_0100, 4'hF, 32'h1234_5678, 0);
        chk("unmapped_rd", {32'd0, read_data}, 64'd0);

        // Cycle counter
        cyc(A_LO, 4'h0, 0, 0);
        v0 = read_data;
        repeat (9) cyc(A_LO, 4'h0, 0, 0);
        cyc(A_LO, 4'h0, 0, 0);
        chk("cyc_delta10", {32'd0, read_data - v0}, 64'd10);
        cyc(A_HI, 4'h0, 0, 0);
        chk("cyc_hi", {32'd0, read_data}, 64'd0);
        cyc(A_LO, 4'h0, 0, 0);
        v0 = read_data;
        cyc(A_LO, 4'hF, 32'hFFFF_FFFF, 0);
        cyc(A_LO, 4'h0, 0, 0);
        v1 = read_data;
        chk("cyc_wr_ignored", {32'd0, v1 - v0}, 64'd2);

        // Fill past full
        for (int i = 1; i <= 9; i++) cyc(A_TX, 4'h1, 32'(i), 0);
        cyc(A_ST, 4'h0, 0, 0);
        chk("fill_status", {32'd0, read_data}, 64'h0001_0208);
        chk("fill_head", {56'd0, tx_data}, 64'h01);

        // Drain in order
        for (int i = 1; i <= 8; i++) begin
            cyc(A_ST, 4'h0, 0, 1);
            chk("drain_valid", {63'd0, tx_valid}, 64'd1);
            chk("drain_data", {56'd0, tx_data}, 64'(i));
        end
        cyc(A_ST, 4'h0, 0, 0);
        chk("drain_empty_valid", {63'd0, tx_valid}, 64'd0);
        chk("drain_status", {32'd0, read_data}, 64'h0001_0100);
        cyc(A_ST, 4'h4, 32'h0001_0000, 0);
        cyc(A_ST, 4'h0, 0, 0);
        chk("ovf_clear", {32'd0, read_data}, 64'h100);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) cyc(A_TX, 4'h1, 32'(8'hA0 + i), 0);
        cyc(A_TX, 4'h1, 32'h55, 1);
        cyc(A_ST, 4'h0, 0, 0);
        chk("full_pushpop", {32'd0, read_data}, 64'h208);
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'h55};
        for (int i = 0; i < 8; i++) begin
            cyc(A_ST, 4'h0, 0, 1);
            chk("pushpop_order", {56'd0, tx_data}, {56'd0, exp_q[i]});
        end
        cyc(A_ST, 4'h0, 0, 0);
        chk("pushpop_empty", {32'd0, read_data}, 64'h100);

        // Overflow, clear, then reset with bytes queued
        for (int i = 0; i < 8; i++) cyc(A_TX, 4'h1, 32'(8'hB0 + i), 0);
        cyc(A_TX, 4'h1, 32'hEE, 0);
        cyc(A_ST, 4'h4, 32'h0001_0000, 0);
        chk("ovf_set", {32'd0, read_data}, 64'h0001_0208);
        cyc(A_ST, 4'h0, 0, 0);
        chk("ovf_cleared", {32'd0, read_data}, 64'h208);
        repeat (5) cyc(A_ST, 4'h0, 0, 1);
        cyc(A_ST, 4'h0, 0, 0);
        chk("three_left", {32'd0, read_data}, 64'h3);
        chk("three_head", {56'd0, tx_data}, 64'hB5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {63'd0, tx_valid}, 64'd0);
        chk("async_data", {56'd0, tx_data}, 64'd0);
        chk("async_status", {32'd0, read_data}, 64'h100);
        address = 32'h0000_0100;
        #1;
        chk("ram_kept_rst", {32'd0, read_data}, 64'hDEAD_BEEF);
        cyc(A_LO, 4'h0, 0, 0);
        #2 rst_n = 1'b1;
        cyc(A_ST, 4'h0, 0, 0);
        chk("post_rst_status", {32'd0, read_data}, 64'h100);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [3:0]  we;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = $urandom & 32'h0000_303C;
                4, 5, 6:    a = 32'h1000_0008 | ($urandom & 32'h0FFF_FFF0);
                7:          a = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
                8:          a = {4'($urandom_range(2, 15)), 28'($urandom)};
                default:    a = $urandom & 32'h0000_003C;
            endcase
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            cyc(a, we, $urandom, 1'($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        cyc(A_IDL, 4'h0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
